dispensador_fsm: RTL and testbench

Drink-dispensing controller for the coffee vending machine. It sits directly downstream of the coin adder (`Sumador`) and consumes its running balance `Saldo`. On a user order it checks the balance against the drink price and, if the balance covers it, pulses `Aceptada` back to the adder so the balance clears. It then sequences the cup, coffee, water and milk outputs with timed steps and reports the change owed.

---
 rtl/maquina_pkg.sv | 48 ++++
 rtl/dispensador_fsm_temporizador.sv | 26 ++
 rtl/dispensador_fsm.sv | 183 ++++++++++++++++++
 tb/tb_dispensador_fsm.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/maquina_pkg.sv
// Shared types and constants for the vending machine blocks.
// Used by dispensador_fsm; the milk stage is gated by DISPENSADOR_LECHE_EN.
package maquina_pkg;

  typedef enum logic [1:0] {
    SEL_NINGUNA = 2'b00,
    SEL_NEGRO   = 2'b01,
    SEL_LECHE   = 2'b10,
    SEL_CAPU    = 2'b11
  } seleccion_t;

  typedef enum logic [2:0] {
    IDLE,
    VERIFICAR,
    VASO,
    CAFE,
    AGUA,
    LECHE,
    LISTO
  } estado_t;

  localparam int PRECIO_NEGRO = 3;
  localparam int PRECIO_LECHE = 5;
  localparam int PRECIO_CAPU  = 7;

  // Milk stage length in units of one dispensing step
  localparam int MULT_LECHE_NEGRO = 0;
  localparam int MULT_LECHE_LECHE = 1;
  localparam int MULT_LECHE_CAPU  = 2;

  function automatic int precio(input seleccion_t sel);
    case (sel)
      SEL_NEGRO: return PRECIO_NEGRO;
      SEL_LECHE: return PRECIO_LECHE;
      SEL_CAPU:  return PRECIO_CAPU;
      default:   return 0;
    endcase
  endfunction

  function automatic int mult_leche(input seleccion_t sel);
    case (sel)
      SEL_LECHE: return MULT_LECHE_LECHE;
      SEL_CAPU:  return MULT_LECHE_CAPU;
      default:   return MULT_LECHE_NEGRO;
    endcase
  endfunction

endpackage

// File: rtl/dispensador_fsm_temporizador.sv
// Loadable step down-counter; fin is high while the count has reached zero.
module temporizador_pasos #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             carga,
  input  logic [CNT_W-1:0] duracion,
  output logic             fin
);

  logic [CNT_W-1:0] cuenta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cuenta <= '0;
    end else if (carga) begin
      cuenta <= duracion;
    end else if (cuenta != '0) begin
      cuenta <= cuenta - 1'b1;
    end
  end

  assign fin = (cuenta == '0);

endmodule

// File: rtl/dispensador_fsm.sv
// Drink dispensing controller: verifies payment, sequences actuators, reports change.
// Define DISPENSADOR_LECHE_EN to build the milk stage (selections 10 and 11).
module dispensador_fsm
  import maquina_pkg::*;
#(
  parameter int SALDO_W    = 4,
  parameter int TICKS_PASO = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SALDO_W-1:0] Saldo,
  input  logic [1:0]         Seleccion,
  input  logic               Pedir,
  output logic               Aceptada,
  output logic               Rechazo,
  output logic               Vaso,
  output logic               Cafe,
  output logic               Agua,
  output logic               Leche,
  output logic               Listo,
  output logic [SALDO_W-1:0] Vuelto,
  output logic               Ocupado
);

  localparam int CNT_W = $clog2(2 * TICKS_PASO + 1);
  // The timer is loaded with duration-1 so that fin marks the last cycle of a step
  localparam logic [CNT_W-1:0] PASO       = CNT_W'(TICKS_PASO - 1);
  localparam logic [CNT_W-1:0] PASO_LECHE = CNT_W'(MULT_LECHE_LECHE * TICKS_PASO - 1);
  localparam logic [CNT_W-1:0] PASO_CAPU  = CNT_W'(MULT_LECHE_CAPU * TICKS_PASO - 1);

  estado_t            estado;
  seleccion_t         sel_q;
  logic [SALDO_W-1:0] saldo_q;
  logic               pedir_q;
  logic               flanco;
  logic               sel_servible;
  logic               cubre;
  logic [SALDO_W-1:0] precio_sel;
  logic               carga;
  logic [CNT_W-1:0]   duracion;
  logic               fin;

  assign flanco     = Pedir & ~pedir_q;
  assign precio_sel = SALDO_W'(precio(sel_q));
  assign cubre      = (saldo_q >= precio_sel);

`ifdef DISPENSADOR_LECHE_EN
  logic leche_r;
  assign sel_servible = (sel_q != SEL_NINGUNA);
  assign Leche        = leche_r;
`else
  assign sel_servible = (sel_q == SEL_NEGRO);
  assign Leche        = 1'b0;
`endif

  // Reload the step timer on every state entry with the length of the next step
  always_comb begin
    carga    = 1'b0;
    duracion = PASO;
    case (estado)
      VERIFICAR: carga = 1'b1;
      VASO, CAFE: carga = fin;
      AGUA: begin
        carga = fin;
        if (sel_q == SEL_CAPU) begin
          duracion = PASO_CAPU;
        end else if (sel_q == SEL_LECHE) begin
          duracion = PASO_LECHE;
        end
      end
      default: carga = 1'b0;
    endcase
  end

  temporizador_pasos #(
    .CNT_W(CNT_W)
  ) u_temporizador (
    .clk     (clk),
    .rst_n   (rst_n),
    .carga   (carga),
    .duracion(duracion),
    .fin     (fin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= IDLE;
      sel_q    <= SEL_NINGUNA;
      saldo_q  <= '0;
      pedir_q  <= 1'b0;
      Aceptada <= 1'b0;
      Rechazo  <= 1'b0;
      Vaso     <= 1'b0;
      Cafe     <= 1'b0;
      Agua     <= 1'b0;
      Listo    <= 1'b0;
      Vuelto   <= '0;
      Ocupado  <= 1'b0;
`ifdef DISPENSADOR_LECHE_EN
      leche_r  <= 1'b0;
`endif
    end else begin
      pedir_q  <= Pedir;
      Aceptada <= 1'b0;
      Rechazo  <= 1'b0;
      Listo    <= 1'b0;
      case (estado)
        IDLE: begin
          if (flanco && (Seleccion != 2'b00)) begin
            sel_q   <= seleccion_t'(Seleccion);
            saldo_q <= Saldo;
            Ocupado <= 1'b1;
            estado  <= VERIFICAR;
          end
        end
        VERIFICAR: begin
          if (sel_servible && cubre) begin
            Vuelto   <= saldo_q - precio_sel;
            Aceptada <= 1'b1;
            Vaso     <= 1'b1;
            estado   <= VASO;
          end else begin
            Rechazo <= 1'b1;
            Ocupado <= 1'b0;
            estado  <= IDLE;
          end
        end
        VASO: begin
          if (fin) begin
            Vaso   <= 1'b0;
            Cafe   <= 1'b1;
            estado <= CAFE;
          end
        end
        CAFE: begin
          if (fin) begin
            Cafe   <= 1'b0;
            Agua   <= 1'b1;
            estado <= AGUA;
          end
        end
        AGUA: begin
          if (fin) begin
            Agua <= 1'b0;
`ifdef DISPENSADOR_LECHE_EN
            if (sel_q != SEL_NEGRO) begin
              leche_r <= 1'b1;
              estado  <= LECHE;
            end else begin
              Listo  <= 1'b1;
              estado <= LISTO;
            end
`else
            Listo  <= 1'b1;
            estado <= LISTO;
`endif
          end
        end
`ifdef DISPENSADOR_LECHE_EN
        LECHE: begin
          if (fin) begin
            leche_r <= 1'b0;
            Listo   <= 1'b1;
            estado  <= LISTO;
          end
        end
`endif
        LISTO: begin
          Ocupado <= 1'b0;
          estado  <= IDLE;
        end
        default: begin
          Vaso    <= 1'b0;
          Cafe    <= 1'b0;
          Agua    <= 1'b0;
          Ocupado <= 1'b0;
          estado  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dispensador_fsm.sv
// Scoreboard bench for dispensador_fsm with TICKS_PASO = 4.
// Expectations follow DISPENSADOR_LECHE_EN the same way the design build does.
module tb_dispensador_fsm;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] Saldo = '0;
  logic [1:0] Seleccion = '0;
  logic       Pedir = 1'b0;
  logic       Aceptada, Rechazo, Vaso, Cafe, Agua, Leche, Listo, Ocupado;
  logic [3:0] Vuelto;

  always #5 clk = ~clk;

  dispensador_fsm #(
    .SALDO_W   (4),
    .TICKS_PASO(T)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Saldo    (Saldo),
    .Seleccion(Seleccion),
    .Pedir    (Pedir),
    .Aceptada (Aceptada),
    .Rechazo  (Rechazo),
    .Vaso     (Vaso),
    .Cafe     (Cafe),
    .Agua     (Agua),
    .Leche    (Leche),
    .Listo    (Listo),
    .Vuelto   (Vuelto),
    .Ocupado  (Ocupado)
  );

  typedef struct {
    int acc;
    int rech;
    int listo;
    int vaso;
    int cafe;
    int agua;
    int leche;
    int ocup;
    int vuelto;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic checkOutput(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t acepta(input int leche, input int ocup, input int vuelto);
    exp_t e;
    e = '{1, 0, 1, T, T, T, leche, ocup, vuelto};
    return e;
  endfunction

  function automatic exp_t rechaza(input int vuelto);
    exp_t e;
    e = '{0, 1, 0, 0, 0, 0, 0, 1, vuelto};
    return e;
  endfunction

  // Monitor: collects one order from Ocupado rising to the first idle cycle
  bit   active = 0;
  exp_t obs;
  int   coinc, excl;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0;
      end else begin
        if (!active && Ocupado) begin
          active = 1;
          obs = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
          coinc = 0;
          excl = 0;
        end
        if (active) begin
          obs.acc   += int'(Aceptada);
          obs.rech  += int'(Rechazo);
          obs.listo += int'(Listo);
          obs.vaso  += int'(Vaso);
          obs.cafe  += int'(Cafe);
          obs.agua  += int'(Agua);
          obs.leche += int'(Leche);
          obs.ocup  += int'(Ocupado);
          coinc     += int'(Aceptada & Vaso);
          if (int'(Vaso) + int'(Cafe) + int'(Agua) + int'(Leche) > 1) excl++;
          if (!Ocupado) begin
            active = 0;
            if (sb.size() == 0) begin
              checkOutput("unexpected_order", 1, 0);
            end else begin
              e = sb.pop_front();
              checkOutput("aceptada_pulses", obs.acc, e.acc);
              checkOutput("rechazo_pulses", obs.rech, e.rech);
              checkOutput("listo_pulses", obs.listo, e.listo);
              checkOutput("vaso_cycles", obs.vaso, e.vaso);
              checkOutput("cafe_cycles", obs.cafe, e.cafe);
              checkOutput("agua_cycles", obs.agua, e.agua);
              checkOutput("leche_cycles", obs.leche, e.leche);
              checkOutput("ocupado_cycles", obs.ocup, e.ocup);
              checkOutput("vuelto", int'(Vuelto), e.vuelto);
              checkOutput("aceptada_with_vaso", coinc, e.acc);
              checkOutput("actuator_overlap", excl, 0);
            end
          end
        end else if (Aceptada | Rechazo | Listo | Vaso | Cafe | Agua | Leche) begin
          checkOutput("outputs_while_idle", 1, 0);
        end
      end
    end
  end

  task automatic waitIdle();
    bit seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (Ocupado) seen = 1;
      else if (seen) break;
      @(negedge clk);
    end
    checkOutput("order_completed", int'(seen && !Ocupado), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] s, input logic [1:0] sel, input exp_t e);
    sb.push_back(e);
    @(negedge clk);
    Saldo = s;
    Seleccion = sel;
    Pedir = 1'b1;
    @(negedge clk);
    Pedir = 1'b0;
    Saldo = 4'd0;
    Seleccion = 2'b00;
    waitIdle();
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", int'({Aceptada, Rechazo, Vaso, Cafe, Agua, Leche, Listo, Ocupado}), 0);
    checkOutput("reset_vuelto", int'(Vuelto), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(4'd5, 2'b01, acepta(0, 14, 2));
    applyStimulus(4'd2, 2'b01, rechaza(2));
`ifdef DISPENSADOR_LECHE_EN
    applyStimulus(4'd11, 2'b11, acepta(2 * T, 22, 4));
    applyStimulus(4'd7, 2'b11, acepta(2 * T, 22, 0));
    applyStimulus(4'd11, 2'b10, acepta(T, 18, 6));
`else
    applyStimulus(4'd11, 2'b11, rechaza(2));
    applyStimulus(4'd7, 2'b11, rechaza(2));
    applyStimulus(4'd11, 2'b10, rechaza(2));
`endif
    applyStimulus(4'd3, 2'b01, acepta(0, 14, 0));
    applyStimulus(4'd15, 2'b01, acepta(0, 14, 12));

    // An order edge with no drink selected must be ignored
    seen = 0;
    @(negedge clk);
    Saldo = 4'd15;
    Seleccion = 2'b00;
    Pedir = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (Ocupado) seen = 1;
    end
    Pedir = 1'b0;
    checkOutput("sel00_ignored", int'(seen), 0);
    checkOutput("sel00_vuelto_kept", int'(Vuelto), 12);

    // Pedir held high while inputs change mid-dispense: latched black coffee only
    sb.push_back(acepta(0, 14, 2));
    @(negedge clk);
    Saldo = 4'd5;
    Seleccion = 2'b01;
    Pedir = 1'b1;
    repeat (6) @(negedge clk);
    Saldo = 4'd15;
    Seleccion = 2'b11;
    waitIdle();
    repeat (6) @(negedge clk);
    Pedir = 1'b0;
    Saldo = 4'd0;
    Seleccion = 2'b00;
    repeat (2) @(negedge clk);

    // Reset asserted during CAFE drops everything at once
    @(negedge clk);
    Saldo = 4'd5;
    Seleccion = 2'b01;
    Pedir = 1'b1;
    @(negedge clk);
    Pedir = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (Cafe) break;
      @(negedge clk);
    end
    checkOutput("reached_cafe", int'(Cafe), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs", int'({Aceptada, Rechazo, Vaso, Cafe, Agua, Leche, Listo, Ocupado}), 0);
    checkOutput("async_reset_vuelto", int'(Vuelto), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(4'd5, 2'b01, acepta(0, 14, 2));

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
